// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared fetch-state and next-PC encodings plus reset defaults
//
// Purpose: types and constants shared by the fetch sequencer and execute.
// Ports: none (package).
package core_pkg;

   // Fetch controller states: request issued, response pending, instruction held for decode
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   // Next-PC select used by execute when it muxes the redirect target
   typedef enum logic [1:0] {
      NPC_PLUS4   = 2'b00,
      NPC_PC_OFF  = 2'b01,
      NPC_RS1_OFF = 2'b10,
      NPC_JALR    = 2'b11
   } npc_sel_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          CNT_W_DEFAULT    = 16;

   // Instructions are word aligned; low address bits are discarded on redirect
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
//
// Purpose: counts inc pulses, sticks at all-ones, clears to zero on clr.
// Ports:
//   clk  in   clock, rising edge
//   clr  in   synchronous clear, has priority over inc
//   inc  in   count one event this cycle
//   cnt  out  current count (CNT_W bits)
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller owning the program counter
//
// Purpose: issues one instruction-memory request at a time, buffers the returned
// word for decode, and applies execute-side redirects, killing any fetch in flight.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   imem_req/imem_addr         fetch request and address (out)
//   imem_gnt/imem_rvalid/rdata memory grant, response valid and data (in)
//   br_valid/br_target         redirect pulse and target from execute (in)
//   inst_valid/inst_ready      decode handshake; inst_data/inst_pc held pair (out)
//   pc_out                     current fetch PC (registered)
//   misalign_err               one-cycle pulse for a redirect with target[1:0] != 0
//   fetch_cnt/flush_cnt        saturating delivered-instruction and redirect counts
module fetch_sequencer
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          CNT_W    = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   input  logic             br_valid,
   input  logic [31:0]      br_target,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst_data,
   output logic [31:0]      inst_pc,
   output logic [31:0]      pc_out,
   output logic             misalign_err,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  inst_data_q, inst_data_d;
   logic [31:0]  inst_pc_q, inst_pc_d;
   logic         kill_q, kill_d;
   logic         misalign_q, misalign_d;
   logic         take_inst;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_data_d = inst_data_q;
      inst_pc_d   = inst_pc_q;
      kill_d      = kill_q;
      misalign_d  = 1'b0;
      take_inst   = 1'b0;
      if (br_valid) begin
         // Redirect wins over every other event this cycle
         pc_d       = align_word(br_target);
         misalign_d = |br_target[1:0];
         case (state_q)
            S_REQ: begin
               // A grant in the same cycle still launches the old request; its data must die
               if (imem_gnt) begin
                  kill_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  kill_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  kill_d = 1'b1;
               end
            end
            default: begin
               kill_d  = 1'b0;
               state_d = S_REQ;
            end
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (kill_q) begin
                     kill_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     inst_data_d = imem_rdata;
                     inst_pc_d   = pc_q;
                     state_d     = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               // PC only moves forward once decode has taken the instruction
               if (inst_ready) begin
                  pc_d      = pc_q + 32'd4;
                  take_inst = 1'b1;
                  state_d   = S_REQ;
               end
            end
            default: begin
               kill_d  = 1'b0;
               state_d = S_REQ;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         inst_data_q <= '0;
         inst_pc_q   <= '0;
         kill_q      <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_data_q <= inst_data_d;
         inst_pc_q   <= inst_pc_d;
         kill_q      <= kill_d;
         misalign_q  <= misalign_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
      .clk (clk),
      .clr (rst),
      .inc (take_inst),
      .cnt (fetch_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (br_valid),
      .cnt (flush_cnt)
   );

   // Request is held off while reset is asserted so nothing launches from a stale state
   assign imem_req     = (state_q == S_REQ) && !rst;
   assign imem_addr    = pc_q;
   assign inst_valid   = (state_q == S_HOLD);
   assign inst_data    = inst_data_q;
   assign inst_pc      = inst_pc_q;
   assign pc_out       = pc_q;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, imem_gnt, imem_rvalid, br_valid, inst_ready;
   logic [31:0] imem_rdata, br_target;
   logic        imem_req, inst_valid, misalign_err;
   logic [31:0] imem_addr, inst_data, inst_pc, pc_out;
   logic [15:0] fetch_cnt, flush_cnt;
   logic        s_imem_req, s_inst_valid, s_misalign_err;
   logic [31:0] s_imem_addr, s_inst_data, s_inst_pc, s_pc_out;
   logic [1:0]  s_fetch_cnt, s_flush_cnt;

   fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .br_valid(br_valid), .br_target(br_target),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
      .pc_out(pc_out), .misalign_err(misalign_err), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
   );

   fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .br_valid(br_valid), .br_target(br_target),
      .inst_valid(s_inst_valid), .inst_ready(inst_ready), .inst_data(s_inst_data), .inst_pc(s_inst_pc),
      .pc_out(s_pc_out), .misalign_err(s_misalign_err), .fetch_cnt(s_fetch_cnt), .flush_cnt(s_flush_cnt)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] model_pc = RESET_PC;
   int          exp_fetch = 0;
   int          exp_flush = 0;
   logic        exp_mis = 1'b0;
   bit          gnt_en = 1'b1;
   int          lat = 1;
   bit          pending = 1'b0;
   bit          poison = 1'b0;
   logic [31:0] rsp_addr = '0;
   int          rsp_cnt = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic int sat(input int v, input int w);
      int m;
      m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   // One clock: memory responder drives gnt/rvalid, reference model follows the PC rules
   task automatic tick();
      logic        g, took, br, r;
      logic [31:0] tgt, a;
      g           = imem_req && gnt_en && !pending;
      imem_gnt    = g;
      imem_rvalid = pending && (rsp_cnt == 0);
      imem_rdata  = imem_rvalid ? (poison ? 32'hDEADBEEF : mem_word(rsp_addr)) : $urandom;
      took = inst_valid && inst_ready;
      br   = br_valid;
      tgt  = br_target;
      r    = rst;
      a    = imem_addr;
      @(posedge clk);
      if (imem_rvalid) begin
         pending = 1'b0;
         poison  = 1'b0;
      end else if (pending) begin
         rsp_cnt--;
      end
      if (g) begin
         pending  = 1'b1;
         rsp_addr = a;
         rsp_cnt  = lat - 1;
      end
      if (r) begin
         model_pc = RESET_PC; exp_fetch = 0; exp_flush = 0; exp_mis = 1'b0;
      end else if (br) begin
         model_pc = tgt & ~32'h3; exp_flush++; exp_mis = (tgt[1:0] != 2'b00);
      end else begin
         exp_mis = 1'b0;
         if (took) begin
            model_pc = model_pc + 32'd4; exp_fetch++;
         end
      end
      cyc++;
      @(negedge clk);
      br_valid    = 1'b0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
   endtask

   task automatic wait_req_idle(input string name);
      int k;
      for (k = 0; k < 20 && !(imem_req && !pending); k++) tick();
      checks++;
      if (k == 20) begin errors++; $display("FAIL %s: no request within %0d cycles", name, k); end
   endtask

   task automatic test_reset();
      rst = 1'b1; inst_ready = 1'b0; br_valid = 1'b0; br_target = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      @(negedge clk);
      tick(); tick();
      checks++;
      if ({imem_req, inst_valid, misalign_err, fetch_cnt, flush_cnt, inst_data, inst_pc} !== '0) begin
         errors++; $display("FAIL reset_zero: req=%0b v=%0b mis=%0b fc=%0d flc=%0d d=%h pc=%h want all 0",
                            imem_req, inst_valid, misalign_err, fetch_cnt, flush_cnt, inst_data, inst_pc);
      end
      checks++;
      if (pc_out !== RESET_PC || imem_addr !== RESET_PC) begin
         errors++; $display("FAIL reset_pc: pc_out=%h addr=%h want %h", pc_out, imem_addr, RESET_PC);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_release_req: got %0b want 1", imem_req); end
   endtask

   task automatic test_straight_line();
      int n, t_gnt;
      n = 0; t_gnt = -100;
      inst_ready = 1'b1; gnt_en = 1'b1; lat = 1;
      for (int i = 0; i < 40 && n < 5; i++) begin
         if (imem_req && !pending) begin
            checks++;
            if (imem_addr !== 32'(n * 4)) begin
               errors++; $display("FAIL straight_addr: got %h want %h", imem_addr, 32'(n * 4));
            end
            t_gnt = cyc;
         end
         if (inst_valid) begin
            checks++;
            if (inst_pc !== 32'(n * 4) || inst_data !== mem_word(32'(n * 4))) begin
               errors++; $display("FAIL straight_inst: pc=%h data=%h want pc=%h data=%h",
                                  inst_pc, inst_data, 32'(n * 4), mem_word(32'(n * 4)));
            end
            checks++;
            if (cyc - t_gnt != 2) begin
               errors++; $display("FAIL straight_latency: got %0d cycles want 2", cyc - t_gnt);
            end
            n++;
         end
         tick();
      end
      checks++;
      if (n != 5) begin errors++; $display("FAIL straight_count: delivered %0d want 5", n); end
      checks++;
      if (fetch_cnt !== 16'd5 || pc_out !== 32'd20) begin
         errors++; $display("FAIL straight_fetch_cnt: cnt=%0d pc=%h want 5 and 00000014", fetch_cnt, pc_out);
      end
      checks++;
      if (s_fetch_cnt !== 2'd3) begin errors++; $display("FAIL small_cnt_saturate: got %0d want 3", s_fetch_cnt); end
   endtask

   task automatic test_backpressure();
      logic [31:0] cap_d, cap_pc;
      logic [15:0] f0;
      int k;
      inst_ready = 1'b0;
      for (k = 0; k < 20 && !inst_valid; k++) tick();
      checks++;
      if (!inst_valid) begin errors++; $display("FAIL bp_reach_hold: inst_valid=%0b want 1", inst_valid); end
      cap_d = inst_data; cap_pc = inst_pc; f0 = fetch_cnt;
      repeat (5) begin
         tick();
         checks++;
         if (inst_valid !== 1'b1 || inst_data !== cap_d || inst_pc !== cap_pc || imem_req !== 1'b0 || pc_out !== cap_pc) begin
            errors++; $display("FAIL bp_hold: v=%0b d=%h pc=%h req=%0b pc_out=%h want 1 %h %h 0 %h",
                               inst_valid, inst_data, inst_pc, imem_req, pc_out, cap_d, cap_pc, cap_pc);
         end
      end
      inst_ready = 1'b1;
      tick();
      checks++;
      if (pc_out !== cap_pc + 32'd4 || fetch_cnt !== f0 + 16'd1 || inst_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release: pc_out=%h cnt=%0d v=%0b want %h %0d 0",
                            pc_out, fetch_cnt, inst_valid, cap_pc + 32'd4, f0 + 16'd1);
      end
   endtask

   task automatic test_redirect_wait();
      int k;
      inst_ready = 1'b1; lat = 3;
      wait_req_idle("rw_req");
      tick();
      poison = 1'b1; br_valid = 1'b1; br_target = 32'h100;
      tick();
      checks++;
      if (pc_out !== 32'h100 || flush_cnt !== 16'd1) begin
         errors++; $display("FAIL rw_redirect: pc_out=%h flush=%0d want 00000100 1", pc_out, flush_cnt);
      end
      lat = 1;
      for (k = 0; k < 20 && !inst_valid; k++) begin
         if (imem_req && !pending) begin
            checks++;
            if (imem_addr !== 32'h100) begin errors++; $display("FAIL rw_addr: got %h want 00000100", imem_addr); end
         end
         tick();
      end
      checks++;
      if (!inst_valid || inst_pc !== 32'h100 || inst_data !== mem_word(32'h100)) begin
         errors++; $display("FAIL rw_inst: v=%0b pc=%h data=%h want 1 00000100 %h", inst_valid, inst_pc, inst_data, mem_word(32'h100));
      end
   endtask

   task automatic test_redirect_coincide();
      logic [15:0] f0, fl0;
      int k;
      inst_ready = 1'b1; lat = 1;
      wait_req_idle("co_req");
      br_valid = 1'b1; br_target = 32'h340;
      tick();
      for (k = 0; k < 20 && !inst_valid; k++) tick();
      checks++;
      if (!inst_valid || inst_pc !== 32'h340 || inst_data !== mem_word(32'h340)) begin
         errors++; $display("FAIL co_gnt_inst: v=%0b pc=%h data=%h want 1 00000340 %h", inst_valid, inst_pc, inst_data, mem_word(32'h340));
      end
      f0 = fetch_cnt; fl0 = flush_cnt;
      br_valid = 1'b1; br_target = 32'h480;
      tick();
      checks++;
      if (inst_valid !== 1'b0 || fetch_cnt !== f0 || flush_cnt !== fl0 + 16'd1 || pc_out !== 32'h480) begin
         errors++; $display("FAIL co_hold: v=%0b fc=%0d flc=%0d pc=%h want 0 %0d %0d 00000480",
                            inst_valid, fetch_cnt, flush_cnt, pc_out, f0, fl0 + 16'd1);
      end
   endtask

   task automatic test_misalign_wrap();
      int k;
      inst_ready = 1'b1; lat = 1;
      br_valid = 1'b1; br_target = 32'h203;
      tick();
      checks++;
      if (misalign_err !== 1'b1 || pc_out !== 32'h200) begin
         errors++; $display("FAIL mis_pulse: err=%0b pc=%h want 1 00000200", misalign_err, pc_out);
      end
      tick();
      checks++;
      if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %0b want 0", misalign_err); end
      for (k = 0; k < 20 && !inst_valid; k++) begin
         if (imem_req) begin
            checks++;
            if (imem_addr !== 32'h200) begin errors++; $display("FAIL mis_addr: got %h want 00000200", imem_addr); end
         end
         tick();
      end
      br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
      tick();
      for (k = 0; k < 20 && !inst_valid; k++) tick();
      checks++;
      if (!inst_valid || inst_pc !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_inst: v=%0b pc=%h want 1 fffffffc", inst_valid, inst_pc);
      end
      tick();
      for (k = 0; k < 20 && !imem_req; k++) tick();
      checks++;
      if (!imem_req || imem_addr !== 32'h0 || pc_out !== 32'h0) begin
         errors++; $display("FAIL wrap_addr: req=%0b addr=%h pc=%h want 1 00000000 00000000", imem_req, imem_addr, pc_out);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      inst_ready = 1'b1; lat = 3;
      wait_req_idle("rm_req");
      tick();
      poison = 1'b1; rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (pc_out !== RESET_PC || imem_addr !== RESET_PC || fetch_cnt !== 16'd0 || flush_cnt !== 16'd0 || inst_valid !== 1'b0 || s_fetch_cnt !== 2'd0) begin
         errors++; $display("FAIL rm_state: pc=%h addr=%h fc=%0d flc=%0d v=%0b sfc=%0d want %h %h 0 0 0 0",
                            pc_out, imem_addr, fetch_cnt, flush_cnt, inst_valid, s_fetch_cnt, RESET_PC, RESET_PC);
      end
      lat = 1;
      for (k = 0; k < 20 && !inst_valid; k++) begin
         if (imem_req && !pending) begin
            checks++;
            if (imem_addr !== RESET_PC) begin errors++; $display("FAIL rm_addr: got %h want %h", imem_addr, RESET_PC); end
         end
         tick();
      end
      checks++;
      if (!inst_valid || inst_pc !== RESET_PC || inst_data !== mem_word(RESET_PC)) begin
         errors++; $display("FAIL rm_inst: v=%0b pc=%h data=%h want 1 %h %h", inst_valid, inst_pc, inst_data, RESET_PC, mem_word(RESET_PC));
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         checks++;
         if (pc_out !== model_pc || s_pc_out !== model_pc) begin
            errors++; $display("FAIL rand_pc: got %h/%h want %h", pc_out, s_pc_out, model_pc);
         end
         if (imem_req || s_imem_req) begin
            checks++;
            if ((imem_req && imem_addr !== model_pc) || (s_imem_req && s_imem_addr !== model_pc)) begin
               errors++; $display("FAIL rand_addr: got %h/%h want %h", imem_addr, s_imem_addr, model_pc);
            end
         end
         if (inst_valid || s_inst_valid) begin
            checks++;
            if ((inst_valid && (inst_pc !== model_pc || inst_data !== mem_word(model_pc))) ||
                (s_inst_valid && (s_inst_pc !== model_pc || s_inst_data !== mem_word(model_pc)))) begin
               errors++; $display("FAIL rand_inst: pc=%h data=%h want %h %h", inst_pc, inst_data, model_pc, mem_word(model_pc));
            end
         end
         checks++;
         if (imem_req && inst_valid) begin errors++; $display("FAIL rand_req_in_hold: req=%0b valid=%0b", imem_req, inst_valid); end
         checks++;
         if (misalign_err !== exp_mis || s_misalign_err !== exp_mis) begin
            errors++; $display("FAIL rand_misalign: got %0b/%0b want %0b", misalign_err, s_misalign_err, exp_mis);
         end
         checks++;
         if (fetch_cnt !== 16'(sat(exp_fetch, 16)) || flush_cnt !== 16'(sat(exp_flush, 16))) begin
            errors++; $display("FAIL rand_cnt: fc=%0d flc=%0d want %0d %0d", fetch_cnt, flush_cnt, sat(exp_fetch, 16), sat(exp_flush, 16));
         end
         checks++;
         if (s_fetch_cnt !== 2'(sat(exp_fetch, 2)) || s_flush_cnt !== 2'(sat(exp_flush, 2))) begin
            errors++; $display("FAIL rand_small_cnt: fc=%0d flc=%0d want %0d %0d", s_fetch_cnt, s_flush_cnt, sat(exp_fetch, 2), sat(exp_flush, 2));
         end
         inst_ready = ($urandom_range(0, 9) < 7);
         gnt_en     = ($urandom_range(0, 3) != 0);
         lat        = $urandom_range(1, 3);
         br_valid   = ($urandom_range(0, 19) == 0);
         br_target  = $urandom;
         rst        = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_backpressure();
      test_redirect_wait();
      test_redirect_coincide();
      test_misalign_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter and sequences fetches to the instruction memory over a request/grant/response handshake.
- Presents fetched instructions to decode with a valid/ready handshake.
- Applies control-transfer redirects (branch, jal, jalr) resolved in execute, and squashes any fetch in flight.
- Replaces the free-running PC update: the PC advances only when an instruction is consumed, or when a redirect arrives.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- CNT_W, 16, width of the fetch and flush performance counters (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until granted.
- imem_addr  out  32  fetch address; equals pc while imem_req=1.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; at earliest one cycle after gnt.
- imem_rdata  in  32  instruction word.
- br_valid  in  1  single-cycle redirect pulse from execute.
- br_target  in  32  redirect target (PC+offset, rs1+offset or jalr value, already computed).
- inst_valid  out  1  instruction/PC pair valid for decode.
- inst_ready  in  1  decode accepts the pair.
- inst_data  out  32  buffered instruction.
- inst_pc  out  32  address of inst_data.
- pc_out  out  32  current architectural fetch PC.
- misalign_err  out  1  one-cycle pulse: br_target[1:0] != 0.
- fetch_cnt  out  CNT_W  instructions delivered to decode.
- flush_cnt  out  CNT_W  redirects taken.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=S_REQ, pc=RESET_PC, kill=0.
  - All outputs are 0 except pc_out=RESET_PC and imem_addr=RESET_PC.
  - imem_req is gated to 0 while rst=1; it asserts in the first cycle after rst deasserts.
- Reset mid-operation discards any outstanding response. Any imem_rvalid arriving after reset while state=S_REQ is ignored.
- S_REQ:
  - imem_req=1, imem_addr=pc.
  - On imem_gnt → S_WAIT.
- S_WAIT:
  - On imem_rvalid with kill=0: inst_data<=imem_rdata, inst_pc<=pc → S_HOLD.
  - On imem_rvalid with kill=1: drop the data, clear kill → S_REQ.
- S_HOLD:
  - inst_valid=1; inst_data and inst_pc are held stable.
  - On inst_valid&&inst_ready: pc<=pc+4 (modulo 2^32, wraps 32'hFFFF_FFFC→0), fetch_cnt++ → S_REQ.
- Latency: gnt in cycle T, rvalid in T+1, inst_valid in T+2. Only one request is outstanding at a time, so peak throughput is 1 instruction per 3 cycles.
- Redirect (br_valid=1) has priority over every other event in the same cycle:
  - pc<={br_target[31:2],2'b00}; misalign_err=1 the next cycle if br_target[1:0]!=0; flush_cnt++.
  - In S_REQ without gnt: drop the request → S_REQ, with the new address next cycle.
  - In S_REQ with gnt in the same cycle: the old request is accepted; set kill=1 → S_WAIT.
  - In S_WAIT without rvalid: set kill=1, stay in S_WAIT.
  - In S_WAIT with rvalid in the same cycle: drop the data → S_REQ.
  - In S_HOLD: drop the buffered instruction; inst_valid=0 next cycle; an inst_ready in the same cycle is ignored and fetch_cnt does not increment → S_REQ.
- Counters saturate at all-ones and never wrap.
- pc_out is a registered output.

Decomposition:
- Shared package core_pkg holds:
  - state encoding localparams S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2;
  - the existing next-PC select encoding (00 PC+4, 01 PC+offset, 10 rs1+offset, 11 jalr) for execute-side target muxing;
  - RESET_PC default.
- One sub-module: sat_counter (parameter width CNT_W; inc and clr inputs). It is instantiated twice, for fetch_cnt and flush_cnt.

Test Plan:
1. Reset then straight-line fetch:
   - Stimulus: rst high 2 cycles, then low; imem_gnt always 1, rvalid one cycle after gnt; inst_ready=1.
   - Required: imem_addr sequence 0, 4, 8, 12; inst_pc matches each address; fetch_cnt=4 after 4 deliveries.
2. Backpressure:
   - Stimulus: inst_ready=0 for 5 cycles while in S_HOLD.
   - Required: inst_valid stays 1; inst_data and inst_pc stay stable; no new imem_req; pc unchanged; on ready, pc=+4.
3. Redirect while waiting:
   - Stimulus: br_valid with br_target=32'h100 in S_WAIT; rvalid 2 cycles later with rdata=32'hDEADBEEF.
   - Required: the response is dropped and inst_valid never shows DEADBEEF; next imem_addr=32'h100; flush_cnt=1.
4. Redirect coinciding with events:
   - Stimulus: br_valid in the same cycle as imem_gnt; separately, br_valid in the same cycle as inst_ready in S_HOLD.
   - Required: the granted response is killed and fetch restarts at the target; fetch_cnt is unchanged in the second case.
5. Misaligned target and wrap-around:
   - Stimulus: br_target=32'h203.
   - Required: misalign_err pulses for 1 cycle and the fetch address is 32'h200.
   - Stimulus: redirect to 32'hFFFF_FFFC and consume one instruction.
   - Required: next imem_addr=0.
6. Reset mid-operation and counter saturation:
   - Stimulus: assert rst in S_WAIT, then rvalid arrives.
   - Required: the response is ignored; the first fetch after reset is at RESET_PC.
   - Stimulus: run with CNT_W=2 and deliver 5 instructions.
   - Required: fetch_cnt=3.
